// File: rtl/watchdog_reset.sv
// System nRESET source: power-on hold pulse plus a vblank-counted 68k watchdog.
// A missed kick within WD_FRAMES vblank edges re-issues the hold pulse.
module watchdog_reset #(
    parameter int WD_FRAMES   = 8,
    parameter int HOLD_CYCLES = 256
) (
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       WD_KICK,
    input  logic       VBLANK,
    input  logic       WD_DISABLE,
    output logic       nRESET,
    output logic       WD_TIMEOUT,
    output logic [3:0] WD_COUNT
);

    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    FRAME_LAST = 4'(WD_FRAMES - 1);

    typedef enum logic {
        S_HOLD,
        S_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic [3:0]    r_count;
    logic [3:0]    w_count_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          r_vbl_d;
    logic          r_nreset;
    logic          w_vbl_edge;

    assign w_vbl_edge = VBLANK & ~r_vbl_d;

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_count_nxt   = r_count;
        w_timeout_nxt = r_timeout;
        unique case (r_state)
            S_HOLD: begin
                w_count_nxt = 4'd0;
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // Disable and kick both outrank a vblank edge in the same cycle
                if (WD_DISABLE) begin
                    w_count_nxt = 4'd0;
                end else if (WD_KICK) begin
                    w_count_nxt = 4'd0;
                end else if (w_vbl_edge && (r_count == FRAME_LAST)) begin
                    w_state_nxt   = S_HOLD;
                    w_hold_nxt    = '0;
                    w_count_nxt   = 4'd0;
                    w_timeout_nxt = 1'b1;
                end else if (w_vbl_edge) begin
                    w_count_nxt = r_count + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
                w_hold_nxt  = '0;
                w_count_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_count    <= 4'd0;
            r_timeout  <= 1'b0;
            r_vbl_d    <= 1'b0;
            r_nreset   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_count    <= w_count_nxt;
            r_timeout  <= w_timeout_nxt;
            r_vbl_d    <= VBLANK;
            r_nreset   <= (w_state_nxt == S_RUN);
        end
    end

    assign nRESET     = r_nreset;
    assign WD_TIMEOUT = r_timeout;
    assign WD_COUNT   = r_count;

endmodule
